// File: rtl/p_unary_pipe_pkg.sv
// -----------------------------------------------------------------------------
// p_pkg : shared types for the p_unary_pipe slice.
//
// Holds the decoded-length width function, the result record and the
// statistics counter type. The typedefs describe the default 16-bit build.
// Modules with a different W size their own fields with len_w().
// -----------------------------------------------------------------------------
package p_pkg;

    localparam int P_W_DEFAULT     = 16;
    localparam int P_CNT_W_DEFAULT = 32;

    // Width of a binary index into a W-bit word.
    function automatic int len_w(input int w);
        return $clog2(w);
    endfunction

    localparam int P_LEN_W = len_w(P_W_DEFAULT);

    typedef logic [P_LEN_W-1:0] len_t;

    typedef struct packed {
        logic is_unary;
        logic compl;
        len_t len;
    } result_t;

    typedef logic [P_CNT_W_DEFAULT-1:0] stat_cnt_t;

endpackage

// File: rtl/p_1hot_enc.sv
// -----------------------------------------------------------------------------
// p_1hot_enc : converts a one-hot word into the binary index of its set bit.
//
// Ports:
//   i_x    W-bit one-hot word (result is meaningless otherwise)
//   o_idx  binary index of the set bit
// -----------------------------------------------------------------------------
module p_1hot_enc
    import p_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0]         i_x,
    output logic [len_w(W)-1:0]  o_idx
);

    localparam int LEN_W = len_w(W);

    // OR of the indices of all set bits; exact for a one-hot input.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (i_x[i]) begin
                o_idx = o_idx | LEN_W'(i);
            end
        end
    end

endmodule

// File: rtl/p_is_1hot.sv
// -----------------------------------------------------------------------------
// p_is_1hot : reports whether a W-bit word has exactly one bit set.
//
// Ports:
//   i_x        W-bit word under test
//   o_is_1hot  1 when exactly one bit of i_x is set
// -----------------------------------------------------------------------------
module p_is_1hot #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_x,
    output logic         o_is_1hot
);

    // Clearing the lowest set bit leaves zero only for a power of two.
    assign o_is_1hot = (i_x != '0) && ((i_x & (i_x - W'(1))) == '0);

endmodule

// File: rtl/p_unary_pipe.sv
// -----------------------------------------------------------------------------
// p_unary_pipe : two-stage streaming unary/thermometer admission check.
//
// Each accepted word is classified as a unary code (0..01..1), optionally in
// complimented form (1..10..0), and its run length is decoded to binary.
// Results appear two cycles after acceptance; a combinational ready chain
// gives one word per cycle with no bubbles.
//
// Ports:
//   i_clk, i_arst            clock, asynchronous active-high reset
//   i_in_vld / o_in_rdy      input handshake
//   i_in_x                   W-bit input word
//   i_cfg_compl_en           admit complimented form for this word
//   o_out_vld / i_out_rdy    output handshake
//   o_out_is_unary           word is a valid unary code
//   o_out_compl              word was admitted in complimented form
//   o_out_len                decoded run length
//
// Optional feature (macro P_UNARY_PIPE_STATS_EN):
//   i_stat_clr               synchronous clear of the counters
//   o_stat_admit             saturating count of admitted results retired
//   o_stat_reject            saturating count of rejected results retired
// -----------------------------------------------------------------------------
module p_unary_pipe
    import p_pkg::*;
#(
    parameter int W                     = P_W_DEFAULT,
    parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1,
    parameter int CNT_W                 = $bits(stat_cnt_t)
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    input  logic                 i_in_vld,
    output logic                 o_in_rdy,
    input  logic [W-1:0]         i_in_x,
    input  logic                 i_cfg_compl_en,
    output logic                 o_out_vld,
    input  logic                 i_out_rdy,
    output logic                 o_out_is_unary,
    output logic                 o_out_compl,
    output logic [len_w(W)-1:0]  o_out_len
`ifdef P_UNARY_PIPE_STATS_EN
    ,
    input  logic                 i_stat_clr,
    output logic [CNT_W-1:0]     o_stat_admit,
    output logic [CNT_W-1:0]     o_stat_reject
`endif
);

    localparam int LEN_W = len_w(W);

    if (W < 2 || CNT_W < 1) begin : g_bad_param
        $error("p_unary_pipe: W must be >= 2 and CNT_W >= 1");
    end

    logic             s1_adv, s2_adv;
    logic             admit_compl, compl_sel;
    logic [W-1:0]     x_n;
    logic             vld_p1, compl_sel_p1, msb_bad_p1;
    logic [W-1:0]     y_p1;
    logic             y_1hot, is_unary;
    logic [LEN_W-1:0] y_idx;
    logic             vld_p2, is_unary_p2, compl_p2;
    logic [LEN_W-1:0] len_p2;

    assign s2_adv   = ~vld_p2 | i_out_rdy;
    assign s1_adv   = ~vld_p1 | s2_adv;
    assign o_in_rdy = s1_adv;

    // A complimented word is folded back to normal form so one +1/one-hot
    // test covers both: 0..01..1 + 1 is a single bit.
    assign admit_compl = P_ADMIT_COMPLIMENT_EN & i_cfg_compl_en;
    assign compl_sel   = admit_compl & i_in_x[W-1];
    assign x_n         = compl_sel ? ~i_in_x : i_in_x;

    // ---- Stage 1: fold and increment --------------------------------------
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            vld_p1       <= 1'b0;
            compl_sel_p1 <= 1'b0;
            msb_bad_p1   <= 1'b0;
            y_p1         <= '0;
        end else if (s1_adv) begin
            vld_p1 <= i_in_vld;
            if (i_in_vld) begin
                compl_sel_p1 <= compl_sel;
                // A set MSB is only legal when complimented form is admitted;
                // this also rejects all-ones whose +1 wraps to zero.
                msb_bad_p1   <= i_in_x[W-1] & ~admit_compl;
                y_p1         <= x_n + W'(1);
            end
        end
    end

    p_is_1hot #(.W(W)) u_is_1hot (
        .i_x       (y_p1),
        .o_is_1hot (y_1hot)
    );

    p_1hot_enc #(.W(W)) u_1hot_enc (
        .i_x   (y_p1),
        .o_idx (y_idx)
    );

    assign is_unary = y_1hot & ~msb_bad_p1;

    // ---- Stage 2: classify and decode, held while the consumer stalls ------
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            vld_p2      <= 1'b0;
            is_unary_p2 <= 1'b0;
            compl_p2    <= 1'b0;
            len_p2      <= '0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                is_unary_p2 <= is_unary;
                compl_p2    <= compl_sel_p1 & is_unary;
                len_p2      <= is_unary ? y_idx : '0;
            end
        end
    end

    assign o_out_vld      = vld_p2;
    assign o_out_is_unary = is_unary_p2;
    assign o_out_compl    = compl_p2;
    assign o_out_len      = len_p2;

`ifdef P_UNARY_PIPE_STATS_EN
    logic [CNT_W-1:0] admit_cnt, reject_cnt;
    logic             out_hs;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign out_hs = vld_p2 & i_out_rdy;

    // ---- Statistics: counted on output retirement --------------------------
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            admit_cnt  <= '0;
            reject_cnt <= '0;
        end else if (i_stat_clr) begin
            admit_cnt  <= '0;
            reject_cnt <= '0;
        end else if (out_hs) begin
            if (is_unary_p2) begin
                admit_cnt <= sat_inc(admit_cnt);
            end else begin
                reject_cnt <= sat_inc(reject_cnt);
            end
        end
    end

    assign o_stat_admit  = admit_cnt;
    assign o_stat_reject = reject_cnt;
`endif

endmodule

// File: tb/tb_p_unary_pipe.sv
// -----------------------------------------------------------------------------
// tb_p_unary_pipe : self-checking bench for p_unary_pipe (W=16).
//
// Two instances share all inputs: dut admits complimented form, dut0 is
// built with P_ADMIT_COMPLIMENT_EN=0. Statistics checks are compiled in when
// P_UNARY_PIPE_STATS_EN is defined (counters built with CNT_W=4).
// -----------------------------------------------------------------------------
module tb_p_unary_pipe;

    localparam int W     = 16;
    localparam int LEN_W = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic             u;
        logic             c;
        logic [LEN_W-1:0] l;
    } res_t;

    typedef struct {
        logic [W-1:0]     x;
        logic             cfg;
        logic             u;
        logic             c;
        logic [LEN_W-1:0] l;
        logic             u0;
    } dir_t;

    logic             clk     = 1'b0;
    logic             arst    = 1'b1;
    logic             in_vld  = 1'b0;
    logic             cfg     = 1'b0;
    logic             out_rdy = 1'b0;
    logic [W-1:0]     in_x    = '0;
    logic             in_rdy, out_vld, out_u, out_c;
    logic [LEN_W-1:0] out_len;
    logic             in_rdy0, out_vld0, out_u0, out_c0;
    logic [LEN_W-1:0] out_len0;
`ifdef P_UNARY_PIPE_STATS_EN
    logic             stat_clr = 1'b0;
    logic [CNT_W-1:0] st_adm, st_rej, st_adm0, st_rej0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    p_unary_pipe #(.W(W), .P_ADMIT_COMPLIMENT_EN(1'b1), .CNT_W(CNT_W)) dut (
        .i_clk          (clk),
        .i_arst         (arst),
        .i_in_vld       (in_vld),
        .o_in_rdy       (in_rdy),
        .i_in_x         (in_x),
        .i_cfg_compl_en (cfg),
        .o_out_vld      (out_vld),
        .i_out_rdy      (out_rdy),
        .o_out_is_unary (out_u),
        .o_out_compl    (out_c),
        .o_out_len      (out_len)
`ifdef P_UNARY_PIPE_STATS_EN
        ,
        .i_stat_clr     (stat_clr),
        .o_stat_admit   (st_adm),
        .o_stat_reject  (st_rej)
`endif
    );

    p_unary_pipe #(.W(W), .P_ADMIT_COMPLIMENT_EN(1'b0), .CNT_W(CNT_W)) dut0 (
        .i_clk          (clk),
        .i_arst         (arst),
        .i_in_vld       (in_vld),
        .o_in_rdy       (in_rdy0),
        .i_in_x         (in_x),
        .i_cfg_compl_en (cfg),
        .o_out_vld      (out_vld0),
        .i_out_rdy      (out_rdy),
        .o_out_is_unary (out_u0),
        .o_out_compl    (out_c0),
        .o_out_len      (out_len0)
`ifdef P_UNARY_PIPE_STATS_EN
        ,
        .i_stat_clr     (stat_clr),
        .o_stat_admit   (st_adm0),
        .o_stat_reject  (st_rej0)
`endif
    );

    // Reference: a word is unary if it equals 2^k-1 (k < W), or, when
    // complimented form is admitted and its MSB is set, its inverse does.
    function automatic res_t model(input logic [W-1:0] x, input logic c_en,
                                   input logic en);
        res_t         r;
        logic [W-1:0] m;
        r = '0;
        for (int k = 0; k < W; k++) begin
            m = (W'(1) << k) - W'(1);
            if (x == m) begin
                r = '{1'b1, 1'b0, LEN_W'(k)};
            end else if (en && c_en && x[W-1] && (~x == m)) begin
                r = '{1'b1, 1'b1, LEN_W'(k)};
            end
        end
        return r;
    endfunction

    // Mix of normal codes, complimented codes, random words and near-misses.
    function automatic logic [W-1:0] gen_word();
        int           k;
        logic [W-1:0] m;
        logic [W-1:0] w;
        k = $urandom_range(0, W-1);
        m = (W'(1) << k) - W'(1);
        case ($urandom_range(0, 3))
            0:       w = m;
            1:       w = ~m;
            2:       w = W'($urandom);
            default: w = m ^ (W'(1) << $urandom_range(0, W-1));
        endcase
        return w;
    endfunction

    task automatic test_reset();
        arst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_vld, out_u, out_c, out_len} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {out_vld, out_u, out_c, out_len});
        end
        arst = 1'b0;
        #1;
        checks++;
        if (in_rdy !== 1'b1 || in_rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_rdy got %b/%b want 1/1", in_rdy, in_rdy0);
        end
        checks++;
        if (out_vld0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_vld0 got %b want 0", out_vld0);
        end
    endtask

    task automatic test_directed();
        dir_t tbl[9];
        res_t got, want, got0, want0;
        tbl = '{
            '{16'h00FF, 1'b0, 1'b1, 1'b0, 4'd8,  1'b1},
            '{16'hFF00, 1'b1, 1'b1, 1'b1, 4'd8,  1'b0},
            '{16'hFF00, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0},
            '{16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1},
            '{16'hFFFF, 1'b1, 1'b1, 1'b1, 4'd0,  1'b0},
            '{16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0},
            '{16'h7FFF, 1'b0, 1'b1, 1'b0, 4'd15, 1'b1},
            '{16'h8000, 1'b1, 1'b1, 1'b1, 4'd15, 1'b0},
            '{16'h00F7, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0}
        };
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_vld = 1'b1; in_x = tbl[i].x; cfg = tbl[i].cfg; out_rdy = 1'b1;
            @(negedge clk);
            in_vld = 1'b0;
            checks++;
            if (out_vld !== 1'b0) begin
                errors++;
                $display("FAIL latency_early[%0d] got out_vld=%b want 0", i, out_vld);
            end
            @(negedge clk);
            got   = {out_u, out_c, out_len};
            want  = '{tbl[i].u, tbl[i].c, tbl[i].l};
            got0  = {out_u0, out_c0, out_len0};
            want0 = tbl[i].u0 ? res_t'({1'b1, 1'b0, tbl[i].l}) : res_t'(0);
            checks++;
            if (out_vld !== 1'b1 || got !== want) begin
                errors++;
                $display("FAIL directed[%0d] x=%h cfg=%b got vld=%b res=%h want vld=1 res=%h",
                         i, tbl[i].x, tbl[i].cfg, out_vld, got, want);
            end
            checks++;
            if (out_vld0 !== 1'b1 || got0 !== want0) begin
                errors++;
                $display("FAIL directed_nocompl[%0d] x=%h cfg=%b got vld=%b res=%h want vld=1 res=%h",
                         i, tbl[i].x, tbl[i].cfg, out_vld0, got0, want0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[6];
        logic         cf[6];
        res_t         exp_q[$];
        res_t         got, want, prev;
        logic         prev_stall, want_rdy, saw_full;
        int           sent, rcvd, infl;
        sent = 0; rcvd = 0; infl = 0;
        prev_stall = 1'b0; saw_full = 1'b0; prev = '0;
        for (int i = 0; i < 6; i++) begin
            words[i] = gen_word();
            cf[i]    = 1'($urandom);
        end
        for (int c = 0; c < 40 && rcvd < 6; c++) begin
            @(negedge clk);
            in_vld  = (sent < 6);
            in_x    = (sent < 6) ? words[sent] : '0;
            cfg     = (sent < 6) ? cf[sent] : 1'b0;
            out_rdy = !(c >= 3 && c <= 5);
            #1;
            got = {out_u, out_c, out_len};
            if (prev_stall) begin
                checks++;
                if (out_vld !== 1'b1 || got !== prev) begin
                    errors++;
                    $display("FAIL b2b_hold c=%0d got vld=%b res=%h want vld=1 res=%h",
                             c, out_vld, got, prev);
                end
            end
            want_rdy = (infl < 2) || out_rdy;
            if (!want_rdy) saw_full = 1'b1;
            checks++;
            if (in_rdy !== want_rdy) begin
                errors++;
                $display("FAIL b2b_in_rdy c=%0d got %b want %b", c, in_rdy, want_rdy);
            end
            if (out_vld && out_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra c=%0d got res=%h want none", c, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL b2b_order c=%0d got %h want %h", c, got, want);
                    end
                end
                rcvd++;
                infl--;
            end
            if (in_vld && in_rdy) begin
                exp_q.push_back(model(in_x, cfg, 1'b1));
                sent++;
                infl++;
            end
            prev_stall = out_vld && !out_rdy;
            prev       = got;
        end
        in_vld = 1'b0; out_rdy = 1'b1;
        checks++;
        if (rcvd != 6 || sent != 6 || exp_q.size() != 0 || !saw_full) begin
            errors++;
            $display("FAIL b2b_count got rcvd=%0d sent=%0d left=%0d full=%b want 6 6 0 1",
                     rcvd, sent, exp_q.size(), saw_full);
        end
    endtask

    task automatic test_random();
        res_t exp_q[$];
        res_t exp0_q[$];
        res_t got, got0, want, want0;
        logic want_rdy;
        int   infl;
        infl = 0;
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            in_vld  = (c < 400) && ($urandom_range(0, 9) < 7);
            in_x    = gen_word();
            cfg     = 1'($urandom);
            out_rdy = (c >= 400) || ($urandom_range(0, 9) < 7);
            #1;
            want_rdy = (infl < 2) || out_rdy;
            if (in_rdy !== want_rdy) begin
                checks++;
                errors++;
                $display("FAIL rand_in_rdy c=%0d got %b want %b", c, in_rdy, want_rdy);
            end
            if (out_vld && out_rdy) begin
                got  = {out_u, out_c, out_len};
                got0 = {out_u0, out_c0, out_len0};
                checks++;
                if (exp_q.size() == 0 || exp0_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra c=%0d got %h want none", c, got);
                end else begin
                    want  = exp_q.pop_front();
                    want0 = exp0_q.pop_front();
                    if (got !== want || got0 !== want0) begin
                        errors++;
                        $display("FAIL rand_result c=%0d got %h/%h want %h/%h",
                                 c, got, got0, want, want0);
                    end
                end
                infl--;
            end
            if (in_vld && in_rdy) begin
                exp_q.push_back(model(in_x, cfg, 1'b1));
                exp0_q.push_back(model(in_x, cfg, 1'b0));
                infl++;
            end
        end
        in_vld = 1'b0;
        checks++;
        if (exp_q.size() != 0 || out_vld !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain got left=%0d vld=%b want 0 0", exp_q.size(), out_vld);
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        in_vld = 1'b1; in_x = 16'h003F; cfg = 1'b0; out_rdy = 1'b0;
        @(negedge clk);
        in_x = 16'hFFF0; cfg = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        #1;
        checks++;
        if (out_vld !== 1'b1 || in_rdy !== 1'b0) begin
            errors++;
            $display("FAIL flight_full got vld=%b rdy=%b want 1 0", out_vld, in_rdy);
        end
        arst = 1'b1;
        #1;
        checks++;
        if (out_vld !== 1'b0 || out_vld0 !== 1'b0) begin
            errors++;
            $display("FAIL flight_reset got vld=%b/%b want 0/0", out_vld, out_vld0);
        end
        @(negedge clk);
        arst = 1'b0; out_rdy = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL flight_rdy got %b want 1", in_rdy);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (out_vld !== 1'b0 || out_vld0 !== 1'b0) begin
                errors++;
                $display("FAIL flight_stale c=%0d got vld=%b/%b want 0/0", c, out_vld, out_vld0);
            end
        end
    endtask

`ifdef P_UNARY_PIPE_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        in_vld = 1'b0; out_rdy = 1'b1; stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        checks++;
        if (st_adm !== 4'd0 || st_rej !== 4'd0) begin
            errors++;
            $display("FAIL stat_clear got %0d/%0d want 0/0", st_adm, st_rej);
        end
        for (int i = 0; i < 20; i++) begin
            in_vld = 1'b1;
            in_x   = (i < 17) ? W'((32'h1 << (i % 16)) - 1) : 16'h00F7;
            cfg    = 1'b0;
            @(negedge clk);
        end
        in_vld = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (st_adm !== 4'd15 || st_rej !== 4'd3) begin
            errors++;
            $display("FAIL stat_counts got %0d/%0d want 15/3", st_adm, st_rej);
        end
        checks++;
        if (st_adm0 !== 4'd15 || st_rej0 !== 4'd3) begin
            errors++;
            $display("FAIL stat_counts0 got %0d/%0d want 15/3", st_adm0, st_rej0);
        end
        in_vld = 1'b1; in_x = 16'h0000;
        @(negedge clk);
        in_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b1) begin
            errors++;
            $display("FAIL stat_hs_vld got %b want 1", out_vld);
        end
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        checks++;
        if (st_adm !== 4'd0 || st_rej !== 4'd0) begin
            errors++;
            $display("FAIL stat_clr_prio got %0d/%0d want 0/0", st_adm, st_rej);
        end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midflight();
`ifdef P_UNARY_PIPE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/p_unary_pipe.md
Name: p_unary_pipe

Overview:
- Streaming, pipelined successor to the combinational unary/thermometer admission check.
- Accepts a W-bit word per cycle on a valid/ready interface and reports three results: whether the word is unary-coded, whether it is in complimented form, and its decoded run length.
- Complimented-form admission is gated by a compile-time parameter and by a per-word runtime configuration bit.
- Sits between a producer of thermometer codes (e.g. FIFO fill levels, DAC/ADC thermometer words) and a consumer that needs the binary length.

Parameters:
- W, 16, input word width; must be >= 2.
- P_ADMIT_COMPLIMENT_EN, 1, when 0, complimented forms are never admitted, regardless of i_cfg_compl_en.
- LEN_W, $clog2(W), width of decoded length (derived; not overridden).
- CNT_W, 32, statistics counter width (only used with the optional feature).

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  asynchronous, active-high reset.
- i_in_vld  in  1  input word valid.
- o_in_rdy  out  1  block can accept input this cycle.
- i_in_x  in  W  input word.
- i_cfg_compl_en  in  1  admit complimented form for this word; sampled with the word.
- o_out_vld  out  1  result valid.
- i_out_rdy  in  1  consumer accepts result.
- o_out_is_unary  out  1  word is a valid unary code.
- o_out_compl  out  1  word was admitted in complimented form.
- o_out_len  out  LEN_W  decoded run length.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_arst is asynchronous and active-high.
- Reset values: all valid flags 0, all result registers 0, o_in_rdy 1 once reset is released.
- Reset mid-operation: all in-flight words are discarded; no partial output appears.
- Input handshake: a word is accepted when i_in_vld & o_in_rdy.
- Output handshake: a result is retired when o_out_vld & i_out_rdy.
- Output hold: while o_out_vld=1 and i_out_rdy=0, all o_out_* signals stay stable.
- Pipeline: two register stages, S1 and S2.
  - Latency is 2 cycles from acceptance to o_out_vld with no stall. Throughput is 1 word per cycle.
  - s2_adv = ~s2_vld | i_out_rdy.
  - s1_adv = ~s1_vld | s2_adv.
  - o_in_rdy = s1_adv. This is a combinational ready chain with no bubbles.
  - No word is dropped or duplicated. Results leave in input order.
- S1 (on accept) registers:
  - compl_sel = P_ADMIT_COMPLIMENT_EN & i_cfg_compl_en & i_in_x[W-1].
  - msb_bad = i_in_x[W-1] & ~(P_ADMIT_COMPLIMENT_EN & i_cfg_compl_en).
  - x_n = compl_sel ? ~i_in_x : i_in_x.
  - y = x_n + 1, truncated to W bits; the carry-out is dropped.
- S2 registers the following, then drives them on the outputs:
  - is_unary = onehot(y) & ~msb_bad.
  - len = index of the set bit of y, but only when is_unary=1.
  - compl = compl_sel & is_unary.
- Rejected words: when is_unary=0, len=0 and compl=0.
- Boundary codes:
  - All-zero: admitted, len 0, compl 0.
  - All-ones with compliment enabled: admitted, len 0, compl 1.
  - All-ones with compliment disabled: rejected.
  - 0111…1 (normal form): len W-1.
  - 100…0 (complimented form): len W-1.

Optional Feature:
- Macro: P_UNARY_PIPE_STATS_EN.
- When the macro is defined, the block adds these ports:
  - i_stat_clr in 1, synchronous clear.
  - o_stat_admit out CNT_W.
  - o_stat_reject out CNT_W.
- Counter behaviour:
  - Each counter increments on an output handshake whose is_unary is 1 (admit) or 0 (reject).
  - Counters saturate at all-ones.
  - i_stat_clr has priority over a same-cycle increment.
  - Reset value is 0.
- When the macro is not defined, these ports and registers do not exist, and the behaviour is otherwise identical.

Decomposition:
- Package p_pkg holds:
  - The result struct {is_unary, compl, len}.
  - A len_t typedef parameterised via a localparam function of W.
  - The stat_cnt_t typedef.
- Existing p_is_1hot is reused for the one-hot check.
- One new sub-module, p_1hot_enc, converts a one-hot word to its binary index, which gives len.

Test Plan (W=16 unless stated):
1. i_in_x=0x00FF, cfg=0 -> after 2 cycles: is_unary=1, compl=0, len=8.
2. i_in_x=0xFF00, cfg=1 -> is_unary=1, compl=1, len=8. Same word with cfg=0 -> is_unary=0, compl=0, len=0. Build with P_ADMIT_COMPLIMENT_EN=0 and cfg=1 -> is_unary=0.
3. Sweep of boundary and invalid words:
   - 0x0000 -> is_unary=1, len 0.
   - 0xFFFF with cfg=1 -> is_unary=1, compl=1, len 0.
   - 0xFFFF with cfg=0 -> rejected.
   - 0x7FFF -> len 15.
   - 0x8000 with cfg=1 -> compl=1, len 15.
   - 0x00F7 -> rejected.
4. Back-to-back stream of 6 words with i_out_rdy held 0 for cycles 3–5:
   - o_in_rdy=0 once both stages are full.
   - Outputs stay stable while stalled.
   - All 6 results arrive in order, with no loss or duplication.
5. Assert i_arst with 2 words in flight -> o_out_vld=0 immediately. After release, o_in_rdy=1 and no stale result ever appears.
6. With P_UNARY_PIPE_STATS_EN defined and CNT_W=4:
   - 17 admitted words -> o_stat_admit=15 (saturated).
   - 3 rejected words -> o_stat_reject=3.
   - i_stat_clr in the same cycle as a handshake -> both counters read 0 next cycle.
